// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational program ROM, resolves jmp locally.
// Optional FETCH_PERF_CNT_EN adds a saturating count of delivered instructions.
module instruction_fetch #(
    parameter int                ADDR_W     = 4,
    parameter int                INST_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]        JMP_OPCODE = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [INST_W-1:0] rom_instruction,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [7:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [INST_W-1:0]   inst_next;
    logic [ADDR_W-1:0]   inst_pc_next;
    logic                valid_next;
    logic                fetch;
    logic                is_jmp;

    assign rom_address = pc;
    assign is_jmp      = (rom_instruction[INST_W-1 -: 4] == JMP_OPCODE);

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        inst_next    = inst_out;
        inst_pc_next = inst_pc;
        valid_next   = inst_valid;
        fetch        = 1'b0;

        // A redirect wins over everything, including a held instruction.
        if (redirect_valid) begin
            pc_next    = redirect_addr;
            valid_next = 1'b0;
            state_next = RUN;
        end else begin
            case (state)
                BOOT: state_next = RUN;
                RUN, HOLD: begin
                    if (stall && inst_valid) begin
                        state_next = HOLD;
                    end else begin
                        state_next = RUN;
                        fetch      = 1'b1;
                    end
                end
                default: state_next = RUN;
            endcase
        end

        if (fetch) begin
            inst_next    = rom_instruction;
            inst_pc_next = pc;
            // A jmp is consumed here and never presented to decode.
            valid_next   = !is_jmp;
            pc_next      = is_jmp ? rom_instruction[8 +: ADDR_W] : pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            inst_out   <= inst_next;
            inst_pc    <= inst_pc_next;
            inst_valid <= valid_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 8'd0;
        end else if (fetch && !is_jmp) begin
            fetch_count <= sat_inc(fetch_count);
        end
    end
`endif

endmodule
